// File: rtl/mem_access_ctrl_pkg.sv
// rtl/mem_access_ctrl_pkg.sv - shared load/store decode buses, bit indices and FSM encodings for the data-memory port controller
package mem_access_ctrl_pkg;

    localparam int REG_BUS  = 64;
    localparam int LOAD_BUS = 7;
    localparam int SAVE_BUS = 4;

    localparam int LOAD_LB  = 0;
    localparam int LOAD_LH  = 1;
    localparam int LOAD_LW  = 2;
    localparam int LOAD_LD  = 3;
    localparam int LOAD_LBU = 4;
    localparam int LOAD_LHU = 5;
    localparam int LOAD_LWU = 6;

    localparam int SAVE_SB  = 0;
    localparam int SAVE_SH  = 1;
    localparam int SAVE_SW  = 2;
    localparam int SAVE_SD  = 3;

    typedef enum logic [1:0] {
        MAC_IDLE = 2'd0,
        MAC_REQ  = 2'd1,
        MAC_RSP  = 2'd2,
        MAC_DONE = 2'd3
    } mac_state_t;

    function automatic logic is_mem_op(input logic [LOAD_BUS-1:0] load_info,
                                       input logic [SAVE_BUS-1:0] save_info);
        return (|load_info) | (|save_info);
    endfunction

endpackage

// File: rtl/mem_access_ctrl_align_chk.sv
// rtl/mem_access_ctrl_align_chk.sv - combinational natural-alignment check, only built with MEM_ALIGN_CHECK_EN
`ifdef MEM_ALIGN_CHECK_EN
module mem_access_ctrl_align_chk (
    input  logic       is_half,
    input  logic       is_word,
    input  logic       is_dword,
    input  logic [2:0] addr_lo,
    output logic       misaligned
);

    // Byte accesses can never be misaligned, so they need no term here.
    assign misaligned = (is_half  &  addr_lo[0])
                      | (is_word  & |addr_lo[1:0])
                      | (is_dword & |addr_lo);

endmodule
`endif

// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - data-memory port controller: one load/store per access over a valid/ready data bus (optional MEM_ALIGN_CHECK_EN)
module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
#(
    parameter int ADDR_W = 64
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                acc_valid,
    input  logic [LOAD_BUS-1:0] load_info,
    input  logic [SAVE_BUS-1:0] save_info,
    input  logic [ADDR_W-1:0]   mem_addr,
    input  logic [7:0]          byte_enable,
    input  logic [63:0]         mem_wr_data,
    input  logic                flush,
    output logic                acc_stall,
    output logic                acc_done,
    output logic                acc_err,
    output logic [63:0]         mem_rd_data,
    output logic                dbus_req_valid,
    input  logic                dbus_req_ready,
    output logic                dbus_req_we,
    output logic [ADDR_W-1:0]   dbus_req_addr,
    output logic [7:0]          dbus_req_wstrb,
    output logic [63:0]         dbus_req_wdata,
    input  logic                dbus_rsp_valid,
    input  logic [63:0]         dbus_rsp_rdata,
    input  logic                dbus_rsp_err
);

    mac_state_t state;
    logic       killed;
    logic       is_mem;
    logic       misaligned;

    assign is_mem = is_mem_op(load_info, save_info);

`ifdef MEM_ALIGN_CHECK_EN
    mem_access_ctrl_align_chk u_align_chk (
        .is_half    (load_info[LOAD_LH] | load_info[LOAD_LHU] | save_info[SAVE_SH]),
        .is_word    (load_info[LOAD_LW] | load_info[LOAD_LWU] | save_info[SAVE_SW]),
        .is_dword   (load_info[LOAD_LD] | save_info[SAVE_SD]),
        .addr_lo    (mem_addr[2:0]),
        .misaligned (misaligned)
    );
`else
    assign misaligned = 1'b0;
`endif

    // A killed access keeps the pipeline held until its bus response drains.
    assign acc_stall = (acc_valid && is_mem && (state != MAC_DONE))
                    || ((state == MAC_RSP) && killed);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= MAC_IDLE;
            killed         <= 1'b0;
            acc_done       <= 1'b0;
            acc_err        <= 1'b0;
            mem_rd_data    <= '0;
            dbus_req_valid <= 1'b0;
            dbus_req_we    <= 1'b0;
            dbus_req_addr  <= '0;
            dbus_req_wstrb <= '0;
            dbus_req_wdata <= '0;
        end else begin
            acc_done <= 1'b0;
            acc_err  <= 1'b0;
            case (state)
                MAC_IDLE: begin
                    if (acc_valid && is_mem && !flush) begin
                        killed <= 1'b0;
                        if (misaligned) begin
                            acc_done <= 1'b1;
                            acc_err  <= 1'b1;
                            state    <= MAC_DONE;
                        end else begin
                            dbus_req_valid <= 1'b1;
                            dbus_req_we    <= |save_info;
                            dbus_req_addr  <= mem_addr & ~ADDR_W'(7);
                            dbus_req_wstrb <= byte_enable;
                            dbus_req_wdata <= mem_wr_data;
                            state          <= MAC_REQ;
                        end
                    end
                end
                MAC_REQ: begin
                    // An accepted request must be drained even if flushed on the same cycle.
                    if (dbus_req_ready) begin
                        dbus_req_valid <= 1'b0;
                        killed         <= flush;
                        state          <= MAC_RSP;
                    end else if (flush) begin
                        dbus_req_valid <= 1'b0;
                        state          <= MAC_IDLE;
                    end
                end
                MAC_RSP: begin
                    if (dbus_rsp_valid) begin
                        killed <= 1'b0;
                        if (killed || flush) begin
                            state <= MAC_IDLE;
                        end else begin
                            if (!dbus_req_we && !dbus_rsp_err) begin
                                mem_rd_data <= dbus_rsp_rdata;
                            end
                            acc_done <= 1'b1;
                            acc_err  <= dbus_rsp_err;
                            state    <= MAC_DONE;
                        end
                    end else if (flush) begin
                        killed <= 1'b1;
                    end
                end
                MAC_DONE: begin
                    state <= MAC_IDLE;
                end
                default: begin
                    state <= MAC_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb/tb_mem_access_ctrl.sv - randomized scoreboard bench for mem_access_ctrl (honours MEM_ALIGN_CHECK_EN)
module tb_mem_access_ctrl;
    import mem_access_ctrl_pkg::*;

    localparam int ADDR_W = 64;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                acc_valid = 1'b0;
    logic [LOAD_BUS-1:0] load_info = '0;
    logic [SAVE_BUS-1:0] save_info = '0;
    logic [ADDR_W-1:0]   mem_addr = '0;
    logic [7:0]          byte_enable = '0;
    logic [63:0]         mem_wr_data = '0;
    logic                flush = 1'b0;
    logic                acc_stall, acc_done, acc_err;
    logic [63:0]         mem_rd_data;
    logic                dbus_req_valid;
    logic                dbus_req_ready = 1'b0;
    logic                dbus_req_we;
    logic [ADDR_W-1:0]   dbus_req_addr;
    logic [7:0]          dbus_req_wstrb;
    logic [63:0]         dbus_req_wdata;
    logic                dbus_rsp_valid = 1'b0;
    logic [63:0]         dbus_rsp_rdata = '0;
    logic                dbus_rsp_err = 1'b0;

    mem_access_ctrl #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst_n(rst_n), .acc_valid(acc_valid), .load_info(load_info),
        .save_info(save_info), .mem_addr(mem_addr), .byte_enable(byte_enable),
        .mem_wr_data(mem_wr_data), .flush(flush), .acc_stall(acc_stall),
        .acc_done(acc_done), .acc_err(acc_err), .mem_rd_data(mem_rd_data),
        .dbus_req_valid(dbus_req_valid), .dbus_req_ready(dbus_req_ready),
        .dbus_req_we(dbus_req_we), .dbus_req_addr(dbus_req_addr),
        .dbus_req_wstrb(dbus_req_wstrb), .dbus_req_wdata(dbus_req_wdata),
        .dbus_rsp_valid(dbus_rsp_valid), .dbus_rsp_rdata(dbus_rsp_rdata),
        .dbus_rsp_err(dbus_rsp_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [63:0] addr;
        logic [7:0]  wstrb;
        logic [63:0] wdata;
    } req_t;

    typedef struct {
        logic        err;
        logic [63:0] rd;
    } done_t;

    req_t        req_q[$];
    done_t       done_q[$];
    int          n_chk = 0;
    int          n_fail = 0;
    logic [63:0] model_rd = '0;
    int          ld_size[LOAD_BUS] = '{1, 2, 4, 8, 1, 2, 4};
    int          st_size[SAVE_BUS] = '{1, 2, 4, 8};

    task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: compares every presented bus request and every completion against the queues.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (dbus_req_valid) begin
                    if (req_q.size() == 0) begin
                        check64("req_unexpected", 64'(dbus_req_valid), 64'd0);
                    end else begin
                        check64("req_we", 64'(dbus_req_we), 64'(req_q[0].we));
                        check64("req_addr", dbus_req_addr, req_q[0].addr);
                        check64("req_wstrb", 64'(dbus_req_wstrb), 64'(req_q[0].wstrb));
                        check64("req_wdata", dbus_req_wdata, req_q[0].wdata);
                        if (dbus_req_ready || flush) void'(req_q.pop_front());
                    end
                end
                if (acc_done) begin
                    if (done_q.size() == 0) begin
                        check64("done_unexpected", 64'(acc_done), 64'd0);
                    end else begin
                        check64("done_err", 64'(acc_err), 64'(done_q[0].err));
                        check64("done_rd_data", mem_rd_data, done_q[0].rd);
                        check64("done_stall", 64'(acc_stall), 64'd0);
                        void'(done_q.pop_front());
                    end
                end
            end
        end
    end

    task automatic idle_inputs();
        acc_valid = 1'b0; load_info = '0; save_info = '0; flush = 1'b0;
        dbus_req_ready = 1'b0; dbus_rsp_valid = 1'b0; dbus_rsp_err = 1'b0;
    endtask

    // fl: 0 none, 1 flush while request pending, 2 flush after handshake. spur: response on handshake cycle.
    task automatic run_txn(input bit st, input int typ, input logic [63:0] addr,
                           input logic [63:0] wd, input logic [63:0] rdv, input bit er,
                           input int rw_in, input int rd, input int fl_in, input bit spur);
        int          sz, lat, c, last, rw, fl;
        bit          skip, done_seen;
        logic [15:0] be16;
        logic [7:0]  be;
        rw = rw_in;
        fl = fl_in;
        sz = st ? st_size[typ] : ld_size[typ];
`ifdef MEM_ALIGN_CHECK_EN
        skip = (addr % 64'(sz)) != 0;
`else
        skip = 1'b0;
`endif
        if (skip) fl = 0;
        if (fl == 1 && rw < 1) rw = 1;
        be16 = ((16'd1 << sz) - 16'd1) << addr[2:0];
        be = st ? be16[7:0] : 8'h00;
        acc_valid   = 1'b1;
        load_info   = st ? '0 : (LOAD_BUS'(1) << typ);
        save_info   = st ? (SAVE_BUS'(1) << typ) : '0;
        mem_addr    = addr;
        byte_enable = be;
        mem_wr_data = wd;
        if (!skip) req_q.push_back('{st, {addr[63:3], 3'b000}, be, wd});
        if (fl == 0) begin
            if (!skip && !st && !er) model_rd = rdv;
            done_q.push_back('{skip ? 1'b1 : er, model_rd});
        end
        lat  = skip ? 1 : 3 + rw + rd;
        last = (fl == 1) ? rw + 1 : 3 + rw + rd;
        c = 0;
        done_seen = 1'b0;
        while (1) begin
            if (!skip) begin
                dbus_req_ready = (fl != 1) && (c == 1 + rw);
                flush          = (fl == 1 && c == rw) || (fl == 2 && c == 2 + rw);
                dbus_rsp_valid = (fl != 1) && ((c == 2 + rw + rd) || (spur && c == 1 + rw));
                dbus_rsp_rdata = (c == 2 + rw + rd) ? rdv : {$urandom, $urandom};
                dbus_rsp_err   = (c == 2 + rw + rd) ? er : 1'($urandom_range(0, 1));
                if ((fl == 1 && c > rw) || (fl == 2 && c > 2 + rw)) acc_valid = 1'b0;
            end
            @(negedge clk);
            if (acc_done && !done_seen) begin
                done_seen = 1'b1;
                check64("done_latency", 64'(c), 64'(lat));
            end
            if (fl == 2 && c > 2 + rw && c <= 2 + rw + rd) check64("drain_stall", 64'(acc_stall), 64'd1);
            if (fl == 1 && c == rw + 1) check64("flush_req_drop", 64'(dbus_req_valid), 64'd0);
            if (fl == 2 && c == 3 + rw + rd) check64("drain_release", 64'(acc_stall), 64'd0);
            if ((fl == 0 && done_seen) || (fl != 0 && c == last)) break;
            if (c >= 60) begin
                check64("done_timeout", 64'(c), 64'(lat));
                break;
            end
            step();
            c++;
        end
        step();
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        check64("rst_req_valid", 64'(dbus_req_valid), 64'd0);
        check64("rst_done", {62'd0, acc_done, acc_err}, 64'd0);
        check64("rst_rd_data", mem_rd_data, 64'd0);
        check64("rst_req_addr", dbus_req_addr, 64'd0);
        check64("rst_req_fields", {55'd0, dbus_req_we, dbus_req_wstrb}, 64'd0);
        check64("rst_req_wdata", dbus_req_wdata, 64'd0);
        check64("rst_stall", 64'(acc_stall), 64'd0);
        rst_n = 1'b1;
        step();

        run_txn(1'b0, LOAD_LB, 64'h1003, 64'h0, 64'h1122334455667788, 1'b0, 0, 0, 0, 1'b0);
        run_txn(1'b1, SAVE_SB, 64'h2005, 64'hAB << 40, 64'hDEAD_BEEF_0000_0001, 1'b0, 0, 1, 0, 1'b0);
        run_txn(1'b0, LOAD_LD, 64'h4000, 64'h0, 64'h0102030405060708, 1'b0, 4, 0, 0, 1'b0);
        run_txn(1'b0, LOAD_LW, 64'h5000, 64'h0, 64'hFFFF_0000_FFFF_0000, 1'b0, 3, 0, 1, 1'b0);
        run_txn(1'b0, LOAD_LD, 64'h6000, 64'h0, 64'hCAFE_F00D_CAFE_F00D, 1'b0, 0, 3, 2, 1'b0);
        run_txn(1'b1, SAVE_SD, 64'h7000, 64'h5555_AAAA_5555_AAAA, 64'h1234, 1'b0, 0, 0, 0, 1'b0);
        run_txn(1'b0, LOAD_LH, 64'h8002, 64'h0, 64'h7777_7777_7777_7777, 1'b1, 1, 1, 0, 1'b1);
        run_txn(1'b0, LOAD_LW, 64'h3002, 64'h0, 64'h3333_4444_5555_6666, 1'b0, 0, 0, 0, 1'b0);

        for (int i = 0; i < 40; i++) begin
            bit st;
            int fsel;
            st   = 1'($urandom_range(0, 1));
            fsel = $urandom_range(0, 5);
            run_txn(st, st ? $urandom_range(0, SAVE_BUS - 1) : $urandom_range(0, LOAD_BUS - 1),
                    {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
                    $urandom_range(0, 5) == 0, $urandom_range(0, 3), $urandom_range(0, 3),
                    (fsel < 4) ? 0 : fsel - 3, $urandom_range(0, 3) == 0);
        end

        acc_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check64("nonmem_stall", 64'(acc_stall), 64'd0);
            step();
        end
        idle_inputs();

        acc_valid = 1'b1;
        load_info = LOAD_BUS'(1) << LOAD_LD;
        mem_addr  = 64'h9000;
        step();
        rst_n = 1'b0;
        #1;
        check64("midrst_req_valid", 64'(dbus_req_valid), 64'd0);
        check64("midrst_rd_data", mem_rd_data, 64'd0);
        check64("midrst_req_addr", dbus_req_addr, 64'd0);
        model_rd = '0;
        idle_inputs();
        step();
        rst_n = 1'b1;
        step();
        run_txn(1'b1, SAVE_SW, 64'hA004, 64'h9999_8888_0000_0000, 64'h0, 1'b0, 0, 0, 0, 1'b0);

        repeat (3) step();
        check64("req_q_drained", 64'(req_q.size()), 64'd0);
        check64("done_q_drained", 64'(done_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
